div_tick_stepper: RTL



---
 rtl/div_tick_stepper.sv | 133 +++++++++++++
 1 files changed

// File: rtl/div_tick_stepper.sv
// div_tick_stepper: turns rising edges of one selected divider tap into single-cycle
// ticks and uses them to advance a run/pause/stop step counter with a programmable
// terminal value, direction, synchronous load and optional one-shot halt.
module div_tick_stepper #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter bit          ONE_SHOT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       div_in,
    input  logic [1:0]       sel,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick,
    output logic [WIDTH-1:0] step_cnt,
    output logic             wrap,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    // div_cur is the first sample of div_in, div_prev the one before it
    logic [3:0]       div_cur_q, div_cur_d;
    logic [3:0]       div_prev_q, div_prev_d;
    logic [1:0]       warm_q, warm_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;

    logic armed;
    logic rise;
    logic step;
    logic at_term;

    // Armed two edges after reset release so levels already high at release give no tick
    assign armed   = (warm_q == 2'd2);
    assign rise    = div_cur_q[sel] & ~div_prev_q[sel];
    assign step    = (state_q == StRun) & rise & armed & ~load;
    assign at_term = dir ? (cnt_q >= MaxVal) : (cnt_q == '0);

    // Next-state logic: edge pipeline, counter update and run/pause/done control
    always_comb begin
        div_cur_d  = div_in;
        div_prev_d = div_cur_q;
        warm_d     = armed ? warm_q : warm_q + 2'd1;
        tick_d     = rise & armed;
        wrap_d     = 1'b0;
        cnt_d      = cnt_q;
        state_d    = state_q;

        // Load wins over a coincident step; a DONE restart also yields to load
        if (load) begin
            cnt_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (step) begin
            if (at_term) begin
                wrap_d = 1'b1;
                if (ONE_SHOT) begin
                    cnt_d = dir ? MaxVal : '0;
                end else begin
                    cnt_d = dir ? '0 : MaxVal;
                end
            end else begin
                cnt_d = dir ? cnt_q + One : cnt_q - One;
            end
        end else if ((state_q == StDone) && start && !stop) begin
            cnt_d = dir ? '0 : MaxVal;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !stop) state_d = StRun;
            end
            StRun: begin
                if (stop) begin
                    state_d = StPause;
                end else if (ONE_SHOT && wrap_d) begin
                    state_d = StDone;
                end
            end
            StPause, StDone: begin
                if (start && !stop) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cur_q  <= '0;
            div_prev_q <= '0;
            warm_q     <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StIdle;
        end else begin
            div_cur_q  <= div_cur_d;
            div_prev_q <= div_prev_d;
            warm_q     <= warm_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign busy     = busy_q;
    assign step_cnt = cnt_q;
    assign state    = state_q;

endmodule
